sdm_sinc3_decim: RTL

- Receive-side decoder for the MASH 1-1-1 delta-sigma modulator. It consumes the modulator's 4-bit signed output stream and reconstructs the fractional input word.
- The decoder is a third-order CIC (sinc3) decimator with ratio R = 2^LOG2R. Each decimated output equals the sum of the input weighted by the sinc3 kernel, so DC gain is R^3.
- With LOG2R=8 and a 24-bit modulator, data_o recovers x directly (R^3 = 2^24). It sits beside the modulator in self-check benches and in on-chip divider-ratio monitoring.

---
 rtl/sdm_sinc3_decim.sv | 68 ++++++
 1 files changed

// File: rtl/sdm_sinc3_decim.sv
// Third-order CIC (sinc3) decimator that reconstructs the input word of a
// MASH 1-1-1 delta-sigma modulator from its signed output stream.
module sdm_sinc3_decim #(
  parameter  int IN_W  = 4,
  parameter  int LOG2R = 8,
  localparam int OUT_W = IN_W + 3 * LOG2R
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en_i,
  input  logic signed [IN_W-1:0]  y_i,
  output logic signed [OUT_W-1:0] data_o,
  output logic                    valid_o,
  output logic                    ovf_o
);

  logic signed [OUT_W-1:0] i1, i2, i3;
  logic signed [OUT_W-1:0] d1, d2, d3;
  logic signed [OUT_W-1:0] c1, c2, c3;
  logic signed [OUT_W-1:0] y_ext;
  logic        [LOG2R-1:0] cnt;
  logic                    tick;
  logic                    out_of_range;

  // Integrator and comb arithmetic wraps modulo 2^OUT_W; the combs cancel the
  // integrator wrap exactly, so no saturation is needed anywhere.
  always_comb begin
    y_ext        = {{(OUT_W-IN_W){y_i[IN_W-1]}}, y_i};
    out_of_range = (int'(y_i) < -3) || (int'(y_i) > 4);
    tick         = en_i && (cnt == '1);
    c1           = i3 - d1;
    c2           = c1 - d2;
    c3           = c2 - d3;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i1      <= '0;
      i2      <= '0;
      i3      <= '0;
      d1      <= '0;
      d2      <= '0;
      d3      <= '0;
      cnt     <= '0;
      data_o  <= '0;
      valid_o <= 1'b0;
      ovf_o   <= 1'b0;
    end else begin
      valid_o <= tick;
      if (en_i) begin
        i1  <= i1 + y_ext;
        i2  <= i2 + i1;
        i3  <= i3 + i2;
        cnt <= cnt + LOG2R'(1);
        if (out_of_range) begin
          ovf_o <= 1'b1;
        end
      end
      if (tick) begin
        d1     <= i3;
        d2     <= c1;
        d3     <= c2;
        data_o <= c3;
      end
    end
  end

endmodule
